// File: rtl/pio_edge_in.sv
// Avalon-MM status input port: per-bit synchroniser, runtime-programmable glitch filter,
// edge capture with write-1-to-clear, interrupt mask and registered level interrupt.
module pio_edge_in #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 8,
    parameter int unsigned FILT_RESET  = 0,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [FILT_W-1:0] FiltRst = FILT_W'(FILT_RESET);

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  filt_q, filt_d;
    logic [WIDTH-1:0]  prev_q;
    logic [FILT_W-1:0] cnt_q [WIDTH];
    logic [FILT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]  edgecap_q, edgecap_d;
    logic [FILT_W-1:0] filtlen_q, filtlen_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic              wr_en;
    logic [WIDTH-1:0]  sync;
    logic [WIDTH-1:0]  edge_ev;

    assign wr_en = chipselect && !write_n;
    assign sync  = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == filtlen_q) begin
                filt_d[i] = sync[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // A new filter length restarts every qualification window.
            if (wr_en && address == 2'd3) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_ev = filt_q & ~prev_q;
            1:       edge_ev = ~filt_q & prev_q;
            default: edge_ev = filt_q ^ prev_q;
        endcase
    end

    always_comb begin
        irqmask_d = irqmask_q;
        filtlen_d = filtlen_q;
        edgecap_d = edgecap_q;
        if (wr_en) begin
            case (address)
                2'd1:    irqmask_d = writedata[WIDTH-1:0];
                2'd2:    edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
                2'd3:    filtlen_d = writedata[FILT_W-1:0];
                default: ;
            endcase
        end
        // Set after clear so a same-cycle event is never lost.
        edgecap_d = edgecap_d | edge_ev;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0]  = filt_q;
            2'd1:    readdata_d[WIDTH-1:0]  = irqmask_q;
            2'd2:    readdata_d[WIDTH-1:0]  = edgecap_q;
            default: readdata_d[FILT_W-1:0] = filtlen_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            filtlen_q  <= FiltRst;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            filt_q     <= filt_d;
            prev_q     <= filt_q;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            filtlen_q  <= filtlen_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed bench for pio_edge_in (WIDTH=8, SYNC_STAGES=2, FILTLEN reset 0, rising edges).
module tb_pio_edge_in;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] rdata;

    pio_edge_in #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .FILT_W     (8),
        .FILT_RESET (0),
        .EDGE_TYPE  (0)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_port    = 8'hA5;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_readdata", readdata, 32'h0);
        check_eq("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus_rd(2'd0, rdata);
        check_eq("data_a5", rdata, 32'h0000_00A5);
        bus_rd(2'd2, rdata);
        check_eq("edgecap_a5", rdata, 32'h0000_00A5);
        bus_rd(2'd3, rdata);
        check_eq("filtlen_reset", rdata, 32'h0);
        bus_wr(2'd2, 32'hFFFF_FFFF);
        bus_rd(2'd2, rdata);
        check_eq("edgecap_clr_all", rdata, 32'h0);

        // Falling edges are not captured with rising-edge selection.
        in_port = 8'h00;
        repeat (6) @(posedge clk);
        #1;
        bus_rd(2'd2, rdata);
        check_eq("edgecap_fall_ignored", rdata, 32'h0);
        bus_rd(2'd0, rdata);
        check_eq("data_zero", rdata, 32'h0);

        bus_wr(2'd3, 32'h3);
        bus_rd(2'd3, rdata);
        check_eq("filtlen_3", rdata, 32'h3);

        // Three-sample pulse is shorter than FILTLEN+1 and must be rejected.
        in_port = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        in_port = 8'h00;
        repeat (8) @(posedge clk);
        #1;
        bus_rd(2'd0, rdata);
        check_eq("pulse_data", rdata, 32'h0);
        bus_rd(2'd2, rdata);
        check_eq("pulse_edgecap", rdata, 32'h0);

        // Held level: filt at edge 6 (k+SYNC+FILTLEN), DATA readdata at edge 7.
        address = 2'd0;
        in_port = 8'h01;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("latency_e%0d", j), {31'b0, readdata[0]},
                     (j >= 7) ? 32'h1 : 32'h0);
        end
        bus_rd(2'd2, rdata);
        check_eq("edgecap_bit0", rdata, 32'h1);

        bus_wr(2'd1, 32'h1);
        check_eq("irq_not_yet", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("irq_set", {31'b0, irq}, 32'h1);
        bus_wr(2'd2, 32'h1);
        check_eq("irq_still_set", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #1;
        check_eq("irq_cleared", {31'b0, irq}, 32'h0);

        in_port = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        bus_rd(2'd2, rdata);
        check_eq("fall_bit0_no_cap", rdata, 32'h0);
        check_eq("fall_bit0_irq", {31'b0, irq}, 32'h0);

        // Bit3 rises in filt at edge 6, captured at edge 7: clear lands on edge 7.
        in_port = 8'h08;
        repeat (6) @(posedge clk);
        #1;
        bus_wr(2'd2, 32'h8);
        bus_rd(2'd2, rdata);
        check_eq("set_beats_clear", rdata, 32'h8);
        bus_wr(2'd2, 32'h0);
        bus_rd(2'd2, rdata);
        check_eq("clear_zero_noop", rdata, 32'h8);
        bus_wr(2'd2, 32'h1);
        bus_rd(2'd2, rdata);
        check_eq("clear_other_bit", rdata, 32'h8);
        check_eq("irq_unmasked_bit3", {31'b0, irq}, 32'h0);
        bus_wr(2'd2, 32'hFFFF_FFFF);
        bus_rd(2'd2, rdata);
        check_eq("clear_all", rdata, 32'h0);

        bus_wr(2'd0, 32'hFFFF_FFFF);
        bus_rd(2'd0, rdata);
        check_eq("data_write_ignored", rdata, 32'h8);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_rd(2'd1, rdata);
        check_eq("irqmask_width", rdata, 32'h0000_00FF);
        bus_wr(2'd3, 32'hFFFF_FF03);
        bus_rd(2'd3, rdata);
        check_eq("filtlen_width", rdata, 32'h3);
        bus_wr(2'd1, 32'h0);

        in_port = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        bus_rd(2'd2, rdata);
        check_eq("edgecap_f7", rdata, 32'h0000_00F7);
        check_eq("irq_masked_off", {31'b0, irq}, 32'h0);

        // Mid-run reset: filt restarts at 0, so held-high inputs are recaptured.
        address = 2'd2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midreset_readdata", readdata, 32'h0);
        check_eq("midreset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk);
            #1;
            if (j == 4) check_eq("recap_early", readdata, 32'h0);
            if (j == 5) check_eq("recap_ff", readdata, 32'h0000_00FF);
        end
        check_eq("recap_irq", {31'b0, irq}, 32'h0);
        bus_rd(2'd0, rdata);
        check_eq("recap_data", rdata, 32'h0000_00FF);
        bus_rd(2'd3, rdata);
        check_eq("recap_filtlen", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
